// File: rtl/lut4_cfg_pkg.sv
// Shared definitions for the LUT4 column configuration loader: FSM encoding
// and the layout of one per-LUT configuration word.
package lut4_cfg_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_LOAD   = 2'd1,
    ST_COMMIT = 2'd2,
    ST_INIT   = 2'd3
  } cfg_state_e;

  localparam int CFG_BITS        = 19;
  localparam int CFG_INIT_LSB    = 0;
  localparam int CFG_FF          = 16;
  localparam int CFG_IOMUX       = 17;
  localparam int CFG_SET_NORESET = 18;

endpackage

// File: rtl/lut4_cfg_shadow_bank.sv
// Shadow bank holding one configuration word per LUT; written one word at a
// time by index and read out as a single flat vector for the atomic commit.
module lut4_cfg_shadow_bank #(
  parameter int NUM_LUTS = 8,
  parameter int CFG_BITS = 19,
  parameter int IDX_W    = $clog2(NUM_LUTS)
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_wr_en,
  input  logic [IDX_W-1:0]             i_wr_idx,
  input  logic [CFG_BITS-1:0]          i_wr_data,
  output logic [NUM_LUTS*CFG_BITS-1:0] o_rd_data
);

  logic [CFG_BITS-1:0] r_bank [NUM_LUTS];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < NUM_LUTS; k++) r_bank[k] <= '0;
    end else if (i_wr_en) begin
      for (int k = 0; k < NUM_LUTS; k++) begin
        if (i_wr_idx == IDX_W'(k)) r_bank[k] <= i_wr_data;
      end
    end
  end

  for (genvar g = 0; g < NUM_LUTS; g++) begin : g_rd
    assign o_rd_data[g*CFG_BITS +: CFG_BITS] = r_bank[g];
  end

endmodule

// File: rtl/lut4_cfg_frame_loader.sv
// Column configuration loader: collects a frame of per-LUT words into a shadow
// bank, commits it to ConfigBits in one edge, then pulses the shared SR/EN.
module lut4_cfg_frame_loader #(
  parameter int NUM_LUTS = 8,
  parameter int CFG_BITS = lut4_cfg_pkg::CFG_BITS,
  parameter int WORD_W   = 32
) (
  input  logic                         UserCLK,
  input  logic                         resetn,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [WORD_W-1:0]            s_data,
  input  logic                         s_last,
  input  logic                         user_sr,
  input  logic                         user_en,
  output logic [NUM_LUTS*CFG_BITS-1:0] ConfigBits,
  output logic                         lut_sr,
  output logic                         lut_en,
  output logic                         busy,
  output logic                         done,
  output logic                         err
);
  import lut4_cfg_pkg::*;

  localparam int IDX_W = $clog2(NUM_LUTS);

  cfg_state_e                   r_state;
  logic [IDX_W-1:0]             r_idx;
  logic                         r_ready;
  logic                         r_busy;
  logic                         r_done;
  logic                         r_err;
  logic [NUM_LUTS*CFG_BITS-1:0] r_cfg;

  logic                         w_accept;
  logic                         w_last_slot;
  logic [IDX_W-1:0]             w_wr_idx;
  logic [NUM_LUTS*CFG_BITS-1:0] w_shadow;
  logic                         w_lut_sr;
  logic                         w_lut_en;

  assign w_accept    = s_valid & r_ready;
  assign w_last_slot = (r_idx == IDX_W'(NUM_LUTS - 1));
  assign w_wr_idx    = (r_state == ST_RUN) ? '0 : r_idx;

  if (WORD_W > CFG_BITS) begin : g_unused
    logic w_unused_hi;
    assign w_unused_hi = ^s_data[WORD_W-1:CFG_BITS];
  end

  lut4_cfg_shadow_bank #(
    .NUM_LUTS (NUM_LUTS),
    .CFG_BITS (CFG_BITS),
    .IDX_W    (IDX_W)
  ) u_shadow (
    .i_clk     (UserCLK),
    .i_rst_n   (resetn),
    .i_wr_en   (w_accept),
    .i_wr_idx  (w_wr_idx),
    .i_wr_data (s_data[CFG_BITS-1:0]),
    .o_rd_data (w_shadow)
  );

  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_RUN;
      r_idx   <= '0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_cfg   <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_RUN: begin
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          if (w_accept) begin
            r_idx <= IDX_W'(1);
            // A one-word frame can never be complete.
            if (s_last) begin
              r_err <= 1'b1;
            end else begin
              r_state <= ST_LOAD;
              r_busy  <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (w_accept) begin
            if (w_last_slot && s_last) begin
              r_state <= ST_COMMIT;
              r_ready <= 1'b0;
            end else if (w_last_slot || s_last) begin
              // Length mismatch: drop the frame, ready for a new first word.
              r_state <= ST_RUN;
              r_busy  <= 1'b0;
              r_err   <= 1'b1;
              r_idx   <= '0;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        ST_COMMIT: begin
          r_cfg   <= w_shadow;
          r_state <= ST_INIT;
          r_done  <= 1'b1;
        end
        ST_INIT: begin
          r_state <= ST_RUN;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_idx   <= '0;
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  // Column SR/EN: user pass-through, forced low while the new config lands,
  // then a single SR+EN pulse so each flop takes its SET_NORESET value.
  always_comb begin
    w_lut_sr = 1'b0;
    w_lut_en = 1'b0;
    case (r_state)
      ST_RUN, ST_LOAD: begin
        w_lut_sr = user_sr & resetn;
        w_lut_en = user_en & resetn;
      end
      ST_INIT: begin
        w_lut_sr = 1'b1;
        w_lut_en = 1'b1;
      end
      default: begin
        w_lut_sr = 1'b0;
        w_lut_en = 1'b0;
      end
    endcase
  end

  assign s_ready    = r_ready;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;
  assign ConfigBits = r_cfg;
  assign lut_sr     = w_lut_sr;
  assign lut_en     = w_lut_en;

endmodule

// File: tb/tb_lut4_cfg_frame_loader.sv
// Scoreboard bench for lut4_cfg_frame_loader: frames push expected done/err
// events, a negedge monitor pops and compares them against the DUT.
module tb_lut4_cfg_frame_loader;

  localparam int NL = 8;
  localparam int CB = 19;
  localparam int WW = 32;
  localparam int CW = NL * CB;

  logic          clk;
  logic          resetn;
  logic          s_valid;
  logic          s_ready;
  logic [WW-1:0] s_data;
  logic          s_last;
  logic          user_sr;
  logic          user_en;
  logic [CW-1:0] ConfigBits;
  logic          lut_sr;
  logic          lut_en;
  logic          busy;
  logic          done;
  logic          err;

  typedef struct {
    bit            is_done;
    logic [CW-1:0] cfg;
  } exp_t;

  exp_t          q[$];
  logic [CW-1:0] exp_cfg;
  int            n_cmp;
  int            n_bad;

  lut4_cfg_frame_loader #(
    .NUM_LUTS (NL),
    .CFG_BITS (CB),
    .WORD_W   (WW)
  ) dut (
    .UserCLK    (clk),
    .resetn     (resetn),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .user_sr    (user_sr),
    .user_en    (user_en),
    .ConfigBits (ConfigBits),
    .lut_sr     (lut_sr),
    .lut_en     (lut_en),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every done/err pulse must match the next queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (resetn && (done || err)) begin
      chk("done_err_exclusive", CW'(done & err), '0);
      if (q.size() == 0) begin
        chk("unexpected_event", CW'({done, err}), '0);
      end else begin
        e = q.pop_front();
        chk("event_kind_done", CW'(done), CW'(e.is_done));
        chk("event_kind_err", CW'(err), CW'(!e.is_done));
        chk("event_cfg", ConfigBits, e.cfg);
        if (e.is_done) chk("init_sr_en", CW'({lut_sr, lut_en}), CW'(2'b11));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [WW-1:0] d, input bit last);
    int guard;
    guard   = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    while (!s_ready && guard < 50) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 50) chk("s_ready_timeout", CW'(s_ready), CW'(1));
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic frame(input logic [CB-1:0] base, input logic [CB-1:0] step, input int n,
                       input int last_at, input bit exp_done, input bit gaps, input bit pt_check);
    logic [CW-1:0] pend;
    exp_t          e;
    pend = exp_cfg;
    for (int k = 0; k < n; k++) pend[k*CB +: CB] = base + step * CB'(k);
    e.is_done = exp_done;
    e.cfg     = exp_done ? pend : exp_cfg;
    q.push_back(e);
    if (exp_done) exp_cfg = pend;
    for (int k = 0; k < n; k++) begin
      if (pt_check && k == 3) begin
        user_en = 1'b1;
        user_sr = 1'b0;
        #1;
        chk("load_pt_en", CW'(lut_en), CW'(1));
        chk("load_pt_sr", CW'(lut_sr), CW'(0));
        user_sr = 1'b1;
        user_en = 1'b0;
        #1;
        chk("load_pt_sr_hi", CW'(lut_sr), CW'(1));
        chk("load_pt_en_lo", CW'(lut_en), CW'(0));
        user_sr = 1'b0;
        user_en = 1'b1;
      end
      send({13'h1ABC, base + step * CB'(k)}, (k == last_at));
      if (gaps && k < n - 1) idle(k % 3);
    end
    if (!exp_done) begin
      chk("err_pulse", CW'(err), CW'(1));
      chk("err_ready", CW'(s_ready), CW'(1));
      chk("err_busy", CW'(busy), CW'(0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    exp_cfg = '0;
    resetn  = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    user_sr = 1'b1;
    user_en = 1'b1;

    idle(3);
    chk("rst_cfg", ConfigBits, '0);
    chk("rst_ready", CW'(s_ready), CW'(0));
    chk("rst_busy", CW'(busy), CW'(0));
    chk("rst_done_err", CW'({done, err}), CW'(0));
    chk("rst_sr_en", CW'({lut_sr, lut_en}), CW'(0));
    resetn = 1'b1;
    #1;
    chk("rel_ready_before_edge", CW'(s_ready), CW'(0));
    chk("rel_passthru", CW'({lut_sr, lut_en}), CW'(2'b11));
    idle(1);
    chk("rel_ready", CW'(s_ready), CW'(1));
    chk("rel_busy", CW'(busy), CW'(0));
    user_sr = 1'b0;

    // Full frame with a close look at the commit and init cycles.
    frame(19'h48000, 19'd1, 8, 7, 1'b1, 1'b0, 1'b0);
    chk("commit_en", CW'(lut_en), CW'(0));
    chk("commit_sr", CW'(lut_sr), CW'(0));
    chk("commit_busy", CW'(busy), CW'(1));
    chk("commit_ready", CW'(s_ready), CW'(0));
    idle(1);
    chk("init_cfg", ConfigBits, exp_cfg);
    chk("init_done", CW'(done), CW'(1));
    chk("init_sr_en_direct", CW'({lut_sr, lut_en}), CW'(2'b11));
    chk("init_busy", CW'(busy), CW'(1));
    idle(1);
    chk("post_busy", CW'(busy), CW'(0));
    chk("post_done", CW'(done), CW'(0));
    chk("post_ready", CW'(s_ready), CW'(1));

    // Short frame, then a good one.
    frame(19'h10000, 19'd1, 4, 3, 1'b0, 1'b0, 1'b0);
    chk("short_cfg_kept", ConfigBits, exp_cfg);
    frame(19'h71230, 19'd1, 8, 7, 1'b1, 1'b0, 1'b0);
    idle(2);
    chk("good_after_short", ConfigBits, exp_cfg);

    // Long frame, then a one-word frame in RUN.
    frame(19'h05550, 19'd1, 8, -1, 1'b0, 1'b0, 1'b0);
    chk("long_cfg_kept", ConfigBits, exp_cfg);
    frame(19'h7FFFF, 19'd0, 1, 0, 1'b0, 1'b0, 1'b0);

    // Throttled frame with pass-through checks, then a back-to-back frame.
    frame(19'h25A00, 19'd3, 8, 7, 1'b1, 1'b1, 1'b1);
    frame(19'h3C3C0, 19'd5, 8, 7, 1'b1, 1'b0, 1'b0);
    idle(2);
    chk("b2b_cfg", ConfigBits, exp_cfg);

    // Reset after four words of a frame.
    for (int k = 0; k < 4; k++) send({13'h0, 19'h11110 + CB'(k)}, 1'b0);
    chk("mid_busy", CW'(busy), CW'(1));
    user_en = 1'b1;
    resetn  = 1'b0;
    #1;
    chk("mid_rst_cfg", ConfigBits, '0);
    chk("mid_rst_ready", CW'(s_ready), CW'(0));
    chk("mid_rst_busy", CW'(busy), CW'(0));
    chk("mid_rst_en", CW'(lut_en), CW'(0));
    idle(1);
    resetn  = 1'b1;
    exp_cfg = '0;
    idle(1);
    chk("mid_rel_ready", CW'(s_ready), CW'(1));
    chk("mid_rel_busy", CW'(busy), CW'(0));
    chk("mid_rel_en", CW'(lut_en), CW'(1));
    frame(19'h60006, 19'h10, 8, 7, 1'b1, 1'b0, 1'b0);
    idle(3);
    chk("after_reset_cfg", ConfigBits, exp_cfg);
    chk("scoreboard_drained", CW'(q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
